// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard: carries the decode control word through E, M and W,
// detects read-after-write hazards against in-flight destinations, inserts
// bubbles on stall/flush and counts retired instructions.
// Optional feature macro: CTRL_FWD_EN (adds forward selects, load-use-only stall).
module pipe_ctrl_hazard #(
    parameter int REGADDRW = 4,
    parameter int ALUCTRLW = 3,
    parameter int CNTW     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                validD,
    input  logic                writeEnableDD,
    input  logic                writeDataEnableMD,
    input  logic                resultSelectorWBD,
    input  logic                data2SelectorED,
    input  logic                outFlagD,
    input  logic [ALUCTRLW-1:0] aluControlED,
    input  logic [REGADDRW-1:0] rs1D,
    input  logic [REGADDRW-1:0] rs2D,
    input  logic [REGADDRW-1:0] rdD,
    input  logic                flushE,
    output logic                stallF,
    output logic                stallD,
    output logic [ALUCTRLW-1:0] aluControlE,
    output logic                data2SelectorE,
    output logic [REGADDRW-1:0] rdE,
    output logic                writeDataEnableM,
    output logic                outFlagM,
    output logic [REGADDRW-1:0] rdM,
    output logic                writeEnableW,
    output logic                resultSelectorW,
    output logic [REGADDRW-1:0] rdW,
    output logic [CNTW-1:0]     retiredCount
`ifdef CTRL_FWD_EN
   ,output logic [1:0]          fwdAE,
    output logic [1:0]          fwdBE
`endif
);

    // Each stage only carries the fields still consumed downstream of it.
    typedef struct packed {
        logic                vld;
        logic                we;
        logic                wde;
        logic                rsel;
        logic                d2;
        logic                outf;
        logic [ALUCTRLW-1:0] alu;
        logic [REGADDRW-1:0] rd;
    } e_ctrl_t;

    typedef struct packed {
        logic                vld;
        logic                we;
        logic                wde;
        logic                rsel;
        logic                outf;
        logic [REGADDRW-1:0] rd;
    } m_ctrl_t;

    typedef struct packed {
        logic                vld;
        logic                we;
        logic                rsel;
        logic [REGADDRW-1:0] rd;
    } w_ctrl_t;

    e_ctrl_t       e_d, e_q;
    m_ctrl_t       m_q;
    w_ctrl_t       w_q;
    logic [CNTW-1:0] retired_d, retired_q;
    logic          bubble;

    // Hazard detection: full RAW against E and M, or load-use only with forwarding.
`ifdef CTRL_FWD_EN
    assign stallD = validD & e_q.vld & e_q.we & e_q.rsel &
                    ((e_q.rd == rs1D) | (e_q.rd == rs2D));
`else
    logic matchE, matchM;
    assign matchE = e_q.vld & e_q.we & ((e_q.rd == rs1D) | (e_q.rd == rs2D));
    assign matchM = m_q.vld & m_q.we & ((m_q.rd == rs1D) | (m_q.rd == rs2D));
    assign stallD = validD & (matchE | matchM);
`endif
    assign stallF = stallD;
    assign bubble = stallD | flushE | ~validD;

    // Next E contents: the decoded word, or an all-zero bubble.
    always_comb begin
        e_d = '0;
        if (!bubble) begin
            e_d.vld  = 1'b1;
            e_d.we   = writeEnableDD;
            e_d.wde  = writeDataEnableMD;
            e_d.rsel = resultSelectorWBD;
            e_d.d2   = data2SelectorED;
            e_d.outf = outFlagD;
            e_d.alu  = aluControlED;
            e_d.rd   = rdD;
        end
    end

    // Retired counter wraps naturally at 2^CNTW.
    always_comb begin
        retired_d = retired_q;
        if (w_q.vld) retired_d = retired_q + CNTW'(1);
    end

    // Stage registers and counter; M and W always advance, even on stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            retired_q <= '0;
        end else begin
            e_q       <= e_d;
            m_q       <= '{vld: e_q.vld, we: e_q.we, wde: e_q.wde, rsel: e_q.rsel,
                           outf: e_q.outf, rd: e_q.rd};
            w_q       <= '{vld: m_q.vld, we: m_q.we, rsel: m_q.rsel, rd: m_q.rd};
            retired_q <= retired_d;
        end
    end

`ifdef CTRL_FWD_EN
    logic [REGADDRW-1:0] rs1E_q, rs2E_q;

    // Source addresses follow the instruction into E for forward selection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1E_q <= '0;
            rs2E_q <= '0;
        end else begin
            rs1E_q <= bubble ? '0 : rs1D;
            rs2E_q <= bubble ? '0 : rs2D;
        end
    end

    // Forward selects: M result wins over W result.
    always_comb begin
        fwdAE = 2'b00;
        fwdBE = 2'b00;
        if (m_q.vld & m_q.we & (m_q.rd == rs1E_q))      fwdAE = 2'b10;
        else if (w_q.vld & w_q.we & (w_q.rd == rs1E_q)) fwdAE = 2'b01;
        if (m_q.vld & m_q.we & (m_q.rd == rs2E_q))      fwdBE = 2'b10;
        else if (w_q.vld & w_q.we & (w_q.rd == rs2E_q)) fwdBE = 2'b01;
    end
`endif

    // Every stage output is qualified by its valid bit.
    assign aluControlE      = e_q.alu & {ALUCTRLW{e_q.vld}};
    assign data2SelectorE   = e_q.d2 & e_q.vld;
    assign rdE              = e_q.rd & {REGADDRW{e_q.vld}};
    assign writeDataEnableM = m_q.wde & m_q.vld;
    assign outFlagM         = m_q.outf & m_q.vld;
    assign rdM              = m_q.rd & {REGADDRW{m_q.vld}};
    assign writeEnableW     = w_q.we & w_q.vld;
    assign resultSelectorW  = w_q.rsel & w_q.vld;
    assign rdW              = w_q.rd & {REGADDRW{w_q.vld}};
    assign retiredCount     = retired_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Self-checking bench for pipe_ctrl_hazard: scoreboard of expected E/M/W
// outputs plus scenario checks for stall, flush, reset and counter wrap.
module tb_pipe_ctrl_hazard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        validD = 0, writeEnableDD = 0, writeDataEnableMD = 0;
    logic        resultSelectorWBD = 0, data2SelectorED = 0, outFlagD = 0;
    logic [2:0]  aluControlED = 0;
    logic [3:0]  rs1D = 4'hf, rs2D = 4'hf, rdD = 0;
    logic        flushE = 0;
    logic        stallF, stallD, data2SelectorE, writeDataEnableM, outFlagM;
    logic        writeEnableW, resultSelectorW;
    logic [2:0]  aluControlE;
    logic [3:0]  rdE, rdM, rdW;
    logic [15:0] retiredCount;
`ifdef CTRL_FWD_EN
    logic [1:0]  fwdAE, fwdBE;
`endif

    pipe_ctrl_hazard #(.REGADDRW(4), .ALUCTRLW(3), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .validD(validD), .writeEnableDD(writeEnableDD),
        .writeDataEnableMD(writeDataEnableMD), .resultSelectorWBD(resultSelectorWBD),
        .data2SelectorED(data2SelectorED), .outFlagD(outFlagD),
        .aluControlED(aluControlED), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
        .flushE(flushE), .stallF(stallF), .stallD(stallD),
        .aluControlE(aluControlE), .data2SelectorE(data2SelectorE), .rdE(rdE),
        .writeDataEnableM(writeDataEnableM), .outFlagM(outFlagM), .rdM(rdM),
        .writeEnableW(writeEnableW), .resultSelectorW(resultSelectorW), .rdW(rdW),
        .retiredCount(retiredCount)
`ifdef CTRL_FWD_EN
       ,.fwdAE(fwdAE), .fwdBE(fwdBE)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we, wde, rsel, d2, outf;
        logic [2:0] alu;
        logic [3:0] rd;
    } exp_t;

    typedef struct {
        int   due;
        int   stg;
        exp_t r;
    } sb_t;

    sb_t sbq[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    // Advance one clock, then compare every scoreboard entry that falls due.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                exp_t r = sbq[i].r;
                n_chk++;
                case (sbq[i].stg)
                    0: if ({aluControlE, data2SelectorE, rdE} !== {r.alu, r.d2, r.rd}) begin
                        n_fail++;
                        $display("FAIL sb_E cyc=%0d got alu=%h d2=%b rd=%h exp alu=%h d2=%b rd=%h",
                                 cyc, aluControlE, data2SelectorE, rdE, r.alu, r.d2, r.rd);
                    end
                    1: if ({writeDataEnableM, outFlagM, rdM} !== {r.wde, r.outf, r.rd}) begin
                        n_fail++;
                        $display("FAIL sb_M cyc=%0d got wde=%b out=%b rd=%h exp wde=%b out=%b rd=%h",
                                 cyc, writeDataEnableM, outFlagM, rdM, r.wde, r.outf, r.rd);
                    end
                    default: if ({writeEnableW, resultSelectorW, rdW} !== {r.we, r.rsel, r.rd}) begin
                        n_fail++;
                        $display("FAIL sb_W cyc=%0d got we=%b rsel=%b rd=%h exp we=%b rsel=%b rd=%h",
                                 cyc, writeEnableW, resultSelectorW, rdW, r.we, r.rsel, r.rd);
                    end
                endcase
                sbq.delete(i);
            end
        end
    endtask

    // Drive one decode slot; bub says whether this slot should become a bubble.
    task automatic drive(input logic v, input logic we, input logic wde, input logic rsel,
                         input logic d2, input logic outf, input logic [2:0] alu,
                         input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                         input logic fl, input logic bub);
        exp_t r;
        validD = v; writeEnableDD = we; writeDataEnableMD = wde; resultSelectorWBD = rsel;
        data2SelectorED = d2; outFlagD = outf; aluControlED = alu;
        rs1D = rs1; rs2D = rs2; rdD = rd; flushE = fl;
        r = '0;
        if (v && !bub) r = '{we: we, wde: wde, rsel: rsel, d2: d2, outf: outf, alu: alu, rd: rd};
        sbq.push_back('{due: cyc + 1, stg: 0, r: r});
        sbq.push_back('{due: cyc + 2, stg: 1, r: r});
        sbq.push_back('{due: cyc + 3, stg: 2, r: r});
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 3'd0, 4'hf, 4'hf, 4'h0, 0, 0);
            tick();
        end
    endtask

    task automatic do_reset();
        #1;
        rst = 1'b1;
        sbq.delete();
        validD = 0; flushE = 0; writeEnableDD = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_chk++;
        if ({stallF, stallD, aluControlE, data2SelectorE, rdE, writeDataEnableM, outFlagM,
             rdM, writeEnableW, resultSelectorW, rdW, retiredCount} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold got rdE=%h rdM=%h rdW=%h cnt=%h exp all 0", rdE, rdM, rdW, retiredCount);
        end
        tick();
        rst = 1'b0;
        tick();
        n_chk++;
        if ({stallF, stallD, aluControlE, data2SelectorE, rdE, writeDataEnableM, outFlagM,
             rdM, writeEnableW, resultSelectorW, rdW, retiredCount} !== '0) begin
            n_fail++;
            $display("FAIL reset_release got rdE=%h rdM=%h rdW=%h cnt=%h exp all 0", rdE, rdM, rdW, retiredCount);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 1, 1, 1, 1, 3'd7, 4'hf, 4'hf, 4'(i), 0, 0);
            tick();
        end
        n_chk++;
        if (retiredCount !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_precount got %0d exp 1", retiredCount);
        end
        rst = 1'b1;
        sbq.delete();
        #1;
        n_chk++;
        if ({stallF, stallD, aluControlE, data2SelectorE, rdE, writeDataEnableM, outFlagM,
             rdM, writeEnableW, resultSelectorW, rdW, retiredCount} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset got rdE=%h rdM=%h rdW=%h cnt=%h exp all 0", rdE, rdM, rdW, retiredCount);
        end
        validD = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 3'b101, 4'hf, 4'hf, 4'h3, 0, 0);
        tick();
        n_chk++;
        if (aluControlE !== 3'b101) begin
            n_fail++; $display("FAIL pass_E got %h exp 5", aluControlE);
        end
        idle(1);
        n_chk++;
        if (rdM !== 4'h3) begin
            n_fail++; $display("FAIL pass_M got %h exp 3", rdM);
        end
        idle(1);
        n_chk++;
        if ({writeEnableW, rdW} !== {1'b1, 4'h3}) begin
            n_fail++; $display("FAIL pass_W got we=%b rd=%h exp we=1 rd=3", writeEnableW, rdW);
        end
        idle(1);
        n_chk++;
        if (retiredCount !== 16'd1) begin
            n_fail++; $display("FAIL pass_cnt got %0d exp 1", retiredCount);
        end
        idle(2);
    endtask

    task automatic test_raw_stall();
        idle(3);
        // writer to r5, then reader of r5 immediately behind it
        drive(1, 1, 0, 0, 0, 0, 3'd1, 4'hf, 4'hf, 4'h5, 0, 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 0, 0, 0, 0, 3'd2, 4'h5, 4'hf, 4'h6, 0, 1);
            n_chk++;
            if ({stallD, stallF} !== 2'b11) begin
                n_fail++; $display("FAIL raw_stall%0d got %b exp 11", k, {stallD, stallF});
            end
            tick();
        end
        drive(1, 1, 0, 0, 0, 0, 3'd2, 4'h5, 4'hf, 4'h6, 0, 0);
        n_chk++;
        if ({stallD, stallF} !== 2'b00) begin
            n_fail++; $display("FAIL raw_release got %b exp 00", {stallD, stallF});
        end
        tick();
        idle(3);
        // distance 3: only W holds the writer, no stall
        drive(1, 1, 0, 0, 0, 0, 3'd3, 4'hf, 4'hf, 4'h9, 0, 0);
        tick();
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 3'd4, 4'hf, 4'h9, 4'ha, 0, 0);
        n_chk++;
        if (stallD !== 1'b0) begin
            n_fail++; $display("FAIL raw_wonly got %b exp 0", stallD);
        end
        tick();
        idle(3);
        // register 0 is compared like any other
        drive(1, 1, 0, 0, 0, 0, 3'd1, 4'hf, 4'hf, 4'h0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3'd1, 4'hf, 4'h0, 4'h8, 0, 1);
        n_chk++;
        if (stallD !== 1'b1) begin
            n_fail++; $display("FAIL raw_r0 got %b exp 1", stallD);
        end
        tick();
        drive(1, 0, 0, 0, 0, 0, 3'd1, 4'hf, 4'h0, 4'h8, 0, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3'd1, 4'hf, 4'h0, 4'h8, 0, 0);
        tick();
        idle(3);
    endtask

    task automatic test_flush();
        idle(3);
        drive(1, 0, 0, 0, 0, 0, 3'b001, 4'hf, 4'hf, 4'h8, 1, 1);
        tick();
        n_chk++;
        if ({aluControlE, rdE} !== 7'd0) begin
            n_fail++; $display("FAIL flush_E got alu=%h rd=%h exp 0", aluControlE, rdE);
        end
`ifndef CTRL_FWD_EN
        drive(1, 1, 0, 0, 0, 0, 3'd1, 4'hf, 4'hf, 4'h4, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 3'd6, 4'h4, 4'hf, 4'h9, 1, 1);
        n_chk++;
        if (stallD !== 1'b1) begin
            n_fail++; $display("FAIL flush_stall got %b exp 1", stallD);
        end
        tick();
        drive(1, 1, 0, 0, 0, 0, 3'd6, 4'h4, 4'hf, 4'h9, 0, 1);
        tick();
        drive(1, 1, 0, 0, 0, 0, 3'd6, 4'h4, 4'hf, 4'h9, 0, 0);
        n_chk++;
        if (stallD !== 1'b0) begin
            n_fail++; $display("FAIL flush_release got %b exp 0", stallD);
        end
        tick();
        n_chk++;
        if ({aluControlE, rdE} !== {3'd6, 4'h9}) begin
            n_fail++; $display("FAIL flush_enter got alu=%h rd=%h exp alu=6 rd=9", aluControlE, rdE);
        end
`endif
        idle(3);
    endtask

`ifdef CTRL_FWD_EN
    task automatic test_forwarding();
        idle(3);
        drive(1, 1, 0, 0, 0, 0, 3'd2, 4'hf, 4'hf, 4'h2, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 3'd3, 4'hf, 4'h2, 4'h8, 0, 0);
        n_chk++;
        if (stallD !== 1'b0) begin
            n_fail++; $display("FAIL fwd_nostall got %b exp 0", stallD);
        end
        tick();
        n_chk++;
        if ({fwdAE, fwdBE} !== 4'b0010) begin
            n_fail++; $display("FAIL fwd_M got A=%b B=%b exp A=00 B=10", fwdAE, fwdBE);
        end
        idle(3);
        drive(1, 1, 0, 0, 0, 0, 3'd2, 4'hf, 4'hf, 4'h3, 0, 0);
        tick();
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 3'd3, 4'hf, 4'h3, 4'h8, 0, 0);
        tick();
        n_chk++;
        if (fwdBE !== 2'b01) begin
            n_fail++; $display("FAIL fwd_W got %b exp 01", fwdBE);
        end
        idle(3);
        drive(1, 1, 0, 1, 0, 0, 3'd0, 4'hf, 4'hf, 4'h7, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 3'd5, 4'h7, 4'hf, 4'ha, 0, 1);
        n_chk++;
        if (stallD !== 1'b1) begin
            n_fail++; $display("FAIL fwd_loaduse got %b exp 1", stallD);
        end
        tick();
        drive(1, 1, 0, 0, 0, 0, 3'd5, 4'h7, 4'hf, 4'ha, 0, 0);
        n_chk++;
        if (stallD !== 1'b0) begin
            n_fail++; $display("FAIL fwd_loaduse_rel got %b exp 0", stallD);
        end
        tick();
        n_chk++;
        if (fwdAE !== 2'b01) begin
            n_fail++; $display("FAIL fwd_load_W got %b exp 01", fwdAE);
        end
        idle(3);
    endtask
`endif

    // Random hazard-free traffic: sources 0..7, destinations 8..14.
    task automatic test_back_to_back();
        int nv = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic v = 1'($urandom_range(0, 3) != 0);
            if (v) nv++;
            drive(v, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  3'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(8, 14)), 0, 0);
            n_chk++;
            if (stallD !== 1'b0) begin
                n_fail++; $display("FAIL b2b_stall i=%0d got %b exp 0", i, stallD);
            end
            tick();
        end
        idle(4);
        n_chk++;
        if (retiredCount !== 16'(nv)) begin
            n_fail++; $display("FAIL b2b_count got %0d exp %0d", retiredCount, nv);
        end
    endtask

    task automatic test_counter_wrap();
        int k = 0;
        bit hit = 0;
        do_reset();
        validD = 1; writeEnableDD = 0; rs1D = 4'hf; rs2D = 4'hf; rdD = 4'h0; flushE = 0;
        while (k < 70000 && !hit) begin
            tick();
            k++;
            if (retiredCount === 16'hffff) hit = 1;
        end
        n_chk++;
        if (!hit || k != 65538) begin
            n_fail++; $display("FAIL wrap_reach got hit=%0d ticks=%0d exp hit=1 ticks=65538", hit, k);
        end
        tick();
        n_chk++;
        if (retiredCount !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_zero got %h exp 0000", retiredCount);
        end
        validD = 0;
        idle(3);
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_passthrough();
`ifndef CTRL_FWD_EN
        test_raw_stall();
`endif
        test_flush();
`ifdef CTRL_FWD_EN
        test_forwarding();
`endif
        test_back_to_back();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_hazard.md
Name: pipe_ctrl_hazard

Overview:
- Carries the decode-stage control word down the pipeline: D→E, E→M and M→W registers, each with a valid bit.
- Detects read-after-write hazards between the decode-stage source registers and in-flight destinations, and raises a stall.
- Inserts bubbles on stall and on execute flush.
- Sits directly downstream of the opcode decoder and drives the E/M/WB control of the datapath.

Parameters:
- REGADDRW, 4, register-address width of rs1D/rs2D/rdD.
- ALUCTRLW, 3, width of the ALU control field.
- CNTW, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- validD  in  1  decode stage holds a real instruction
- writeEnableDD  in  1  register-file write request
- writeDataEnableMD  in  1  memory write (store)
- resultSelectorWBD  in  1  WB selects memory data (load)
- data2SelectorED  in  1  ALU operand-2 select
- outFlagD  in  1  output-port write
- aluControlED  in  ALUCTRLW  ALU operation
- rs1D, rs2D, rdD  in  REGADDRW  source/destination register addresses
- flushE  in  1  squash the instruction entering E (taken branch)
- stallF  out  1  hold fetch/PC
- stallD  out  1  hold decode register
- aluControlE  out  ALUCTRLW  E-stage ALU control
- data2SelectorE  out  1  E-stage operand-2 select
- rdE  out  REGADDRW  E-stage destination
- writeDataEnableM  out  1  M-stage store enable
- outFlagM  out  1  M-stage output-port write
- rdM  out  REGADDRW  M-stage destination
- writeEnableW  out  1  register-file write enable
- resultSelectorW  out  1  WB mux select
- rdW  out  REGADDRW  WB destination
- retiredCount  out  CNTW  count of valid instructions leaving W
- fwdAE, fwdBE  out  2  forward selects (present only with CTRL_FWD_EN)

Behaviour:
- Reset: asynchronous. All stage registers, valid bits and retiredCount are cleared to 0. All outputs are 0 while rst is high and on the first edge after release.
- Latency:
  - D inputs appear on E outputs 1 clk later, on M outputs after 2, on W outputs after 3.
  - No combinational path from D inputs to E/M/W outputs.
- Bubble: valid=0 with every control bit and field 0, rd=0. Every E/M/W control output is ANDed with its stage valid.
- Hazard (without CTRL_FWD_EN):
  - stallD = validD & (match(E) | match(M)).
  - match(X) = validX & writeEnableX & (rdX==rs1D | rdX==rs2D).
  - rs2D is always compared, whatever data2SelectorED is.
  - Register 0 has no exemption.
  - W-stage matches do not stall; the register file writes before reading.
- stallF = stallD, combinational.
- Stall cycle:
  - The D→E register loads a bubble.
  - E→M and M→W advance normally.
  - The upstream decoder holds its inputs, and the instruction is re-evaluated next cycle.
- flushE: the D→E register loads a bubble on that edge. stallD is still computed and driven; with both active, the result is a bubble.
- retiredCount increments on every edge where validW=1 and wraps from 2^CNTW-1 to 0.
- No other state; the block contains no FSM beyond the stage registers.

Optional Feature:
- CTRL_FWD_EN defined:
  - rs1/rs2 are also registered into E.
  - fwdAE/fwdBE = 2'b10 if validM & writeEnableM & rdM==rsXE.
  - Otherwise 2'b01 if validW & writeEnableW & rdW==rsXE.
  - Otherwise 2'b00. M has priority over W.
  - stallD = validD & validE & writeEnableE & resultSelectorE & (rdE==rs1D | rdE==rs2D), i.e. load-use only.
- CTRL_FWD_EN undefined:
  - fwdAE/fwdBE ports and rs E-registers are absent.
  - Stall rule is as in Behaviour.

Test Plan:
- Reset mid-stream: assert rst with 3 valid instrs in flight → all outputs 0 immediately; retiredCount=0.
- Passthrough: validD=1, aluControlED=3'b101, writeEnableDD=1, rdD=4'h3 → aluControlE=3'b101 at +1, rdM=3 at +2, writeEnableW=1/rdW=3 at +3, retiredCount=1 at +4.
- RAW stall, no forwarding: instr A rdD=5 write; next cycle rs1D=5 → stallD=stallF=1 for 2 cycles, two bubbles in E, then B enters E; W-only match (distance 3) → no stall.
- Flush: flushE=1 with valid D instr aluControlED=3'b001 → next cycle aluControlE=0, validE=0; flushE and stallD together → single bubble, and no instr is lost after stallD drops.
- Counter wrap: preload via 65535 valid retires (CNTW=16) → retiredCount 0xFFFF then 0x0000.
- CTRL_FWD_EN:
  - ALU writer rd=2 followed by reader rs2=2 → no stall, fwdBE=2'b10.
  - Distance 2 → fwdBE=2'b01.
  - Load (resultSelectorWBD=1) rd=7 followed by user rs1=7 → exactly one stall cycle, then fwdAE=2'b01.
